// File: rtl/spi_host_pkg.sv
// Shared types and constants for the SPI mode-0 host: FSM state encoding and byte geometry.
package spi_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } spi_host_state_e;

  localparam int BitsPerByte = 8;
  localparam int SpiMode     = 0;

endpackage

// File: rtl/spi_host_tick.sv
// SCK timebase: counts ClkDiv cycles per phase and flags the SCK rise/fall edges while shifting.
module spi_host_tick #(
  parameter int ClkDiv = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_run,
  input  logic i_shift,
  output logic o_tick,
  output logic o_rise,
  output logic o_fall
);

  localparam int DivW = $clog2(ClkDiv + 1);
  localparam logic [DivW-1:0] LastCnt = DivW'(ClkDiv - 1);

  logic [DivW-1:0] r_cnt;
  logic            r_phase;
  logic            w_tick;

  assign w_tick = i_run && (r_cnt == LastCnt);

  // r_phase is the SCK level the current phase drives; it restarts low on every SHIFT entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else begin
      if (!i_run || w_tick) r_cnt <= '0;
      else                  r_cnt <= r_cnt + 1'b1;
      if (!i_shift)    r_phase <= 1'b0;
      else if (w_tick) r_phase <= ~r_phase;
    end
  end

  assign o_tick = w_tick;
  assign o_rise = w_tick && i_shift && !r_phase;
  assign o_fall = w_tick && i_shift && r_phase;

endmodule

// File: rtl/spi_host_lite.sv
// Byte-stream SPI mode-0 initiator: bytes in on a valid/ready port, received bytes out as pulses.
module spi_host_lite
  import spi_host_pkg::*;
#(
  parameter int ClkDiv = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_last_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       busy_o,
  output logic       spi_sck_o,
  output logic       spi_csb_o,
  output logic       spi_mosi_o,
  input  logic       spi_miso_i
);

  localparam logic [2:0] LastBit = 3'(BitsPerByte - 1);
  localparam logic       SckIdle = 1'(SpiMode / 2);

  spi_host_state_e r_state, w_next;
  logic [7:0] r_tx, r_rx, r_rx_data;
  logic [2:0] r_bit;
  logic       r_last, r_sck, r_csb, r_mosi, r_ready, r_rx_valid;
  logic       w_run, w_shift, w_tick, w_rise, w_fall, w_accept, w_byte_done;

  // Handshake: a byte moves on a cycle with tx_valid_i && tx_ready_o; tx_ready_o is a flop that
  // is high only in IDLE/WAIT, so data/last are only ever looked at on that cycle.
  assign w_accept    = tx_valid_i && r_ready;
  assign w_shift     = (r_state == ST_SHIFT);
  assign w_run       = (r_state != ST_IDLE) && (r_state != ST_WAIT);
  assign w_byte_done = w_shift && w_fall && (r_bit == LastBit);

  spi_host_tick #(.ClkDiv(ClkDiv)) u_tick (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_run   (w_run),
    .i_shift (w_shift),
    .o_tick  (w_tick),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)    w_next = ST_SETUP;
      ST_SETUP: if (w_tick)      w_next = ST_SHIFT;
      ST_SHIFT: if (w_byte_done) w_next = r_last ? ST_HOLD : ST_WAIT;
      ST_WAIT:  if (w_accept)    w_next = ST_SHIFT;
      ST_HOLD:  if (w_tick)      w_next = ST_GAP;
      ST_GAP:   if (w_tick)      w_next = ST_IDLE;
      default:                   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_bit      <= '0;
      r_last     <= 1'b0;
      r_sck      <= SckIdle;
      r_csb      <= 1'b1;
      r_mosi     <= 1'b0;
      r_ready    <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ready    <= (w_next == ST_IDLE) || (w_next == ST_WAIT);
      r_rx_valid <= 1'b0;
      if (w_accept) begin
        r_tx   <= tx_data_i;
        r_mosi <= tx_data_i[7];
        r_last <= tx_last_i;
        r_bit  <= '0;
        r_csb  <= 1'b0;
      end
      if (w_shift && w_rise) begin
        r_sck <= ~SckIdle;
        r_rx  <= {r_rx[6:0], spi_miso_i};
      end else if (w_shift && w_fall) begin
        r_sck <= SckIdle;
        if (r_bit == LastBit) begin
          r_rx_valid <= 1'b1;
          r_rx_data  <= r_rx;
          r_mosi     <= 1'b0;
        end else begin
          r_bit  <= r_bit + 1'b1;
          r_tx   <= {r_tx[6:0], 1'b0};
          r_mosi <= r_tx[6];
        end
      end
      if ((r_state == ST_HOLD) && w_tick) r_csb <= 1'b1;
    end
  end

  assign tx_ready_o = r_ready;
  assign rx_valid_o = r_rx_valid;
  assign rx_data_o  = r_rx_data;
  assign busy_o     = (r_state != ST_IDLE);
  assign spi_sck_o  = r_sck;
  assign spi_csb_o  = r_csb;
  assign spi_mosi_o = r_mosi;

endmodule

// File: tb/tb_spi_host_lite.sv
// Bench for spi_host_lite: directed scenarios plus random transactions against a timing/data model.
module tb_spi_host_lite;

  localparam int ClkDiv = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid, tx_ready, tx_last, rx_valid, busy;
  logic [7:0] tx_data, rx_data;
  logic       spi_sck, spi_csb, spi_mosi, spi_miso;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  spi_host_lite #(.ClkDiv(ClkDiv)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .tx_data_i  (tx_data),
    .tx_last_i  (tx_last),
    .rx_valid_o (rx_valid),
    .rx_data_o  (rx_data),
    .busy_o     (busy),
    .spi_sck_o  (spi_sck),
    .spi_csb_o  (spi_csb),
    .spi_mosi_o (spi_mosi),
    .spi_miso_i (spi_miso)
  );

  // clock / cycle index (cyc = number of the last rising edge)
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // MISO sources: 0 loopback, 1 tied low, 2 peripheral shifting a response byte on SCK falls
  logic [1:0] miso_sel = 2'd0;
  logic [7:0] resp_sr  = 8'h00;
  assign spi_miso = (miso_sel == 2'd0) ? spi_mosi : (miso_sel == 2'd1) ? 1'b0 : resp_sr[7];
  always @(negedge spi_sck) resp_sr = {resp_sr[6:0], 1'b0};

  // scoreboard queues: {edge cycle, data}
  logic [39:0] exp_q[$];
  logic [32:0] rise_q[$];
  logic [31:0] csb_rise_q[$];
  logic [31:0] csb_fall_q[$];

  logic        p_sck = 1'b0, p_csb = 1'b1;
  int          rise_cnt = 0, rx_cnt = 0, low_cnt = 0, last_low = 0;
  int          last_csb_rise = -1000;
  logic [39:0] m_rx;
  logic [32:0] m_rise;
  logic [31:0] m_edge;

  always @(negedge clk) begin
    if (!rst) begin
      if (spi_sck && !p_sck) begin
        rise_cnt++;
        if (rise_q.size() == 0) check("sck_rise_unexpected", 1, 0);
        else begin
          m_rise = rise_q.pop_front();
          check("sck_rise_cycle", cyc, m_rise[32:1]);
          check("mosi_bit", {31'd0, spi_mosi}, {31'd0, m_rise[0]});
        end
      end
      if (rx_valid) begin
        rx_cnt++;
        if (exp_q.size() == 0) check("rx_unexpected", 1, 0);
        else begin
          m_rx = exp_q.pop_front();
          check("rx_cycle", cyc, m_rx[39:8]);
          check("rx_data", {24'd0, rx_data}, {24'd0, m_rx[7:0]});
        end
      end
      if (!spi_csb && p_csb) begin
        if (csb_fall_q.size() == 0) check("csb_fall_unexpected", 1, 0);
        else begin
          m_edge = csb_fall_q.pop_front();
          check("csb_fall_cycle", cyc, m_edge);
        end
      end
      if (spi_csb && !p_csb) begin
        last_csb_rise = cyc;
        last_low      = low_cnt;
        if (csb_rise_q.size() == 0) check("csb_rise_unexpected", 1, 0);
        else begin
          m_edge = csb_rise_q.pop_front();
          check("csb_rise_cycle", cyc, m_edge);
        end
      end
      if (spi_csb) begin
        low_cnt = 0;
        check("csb_high_pins", {30'd0, spi_sck, spi_mosi}, 0);
      end else low_cnt++;
    end
    p_sck = spi_sck;
    p_csb = spi_csb;
  end

  // driver: offer one byte, wait for the handshake, then record what the model expects
  task automatic send_byte(input logic [7:0] d, input logic last, input bit first,
                           input logic [7:0] resp, input bit toggle);
    int t;
    int acc;
    int start;
    logic [7:0] exp_rx;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    tx_last  = last;
    t = 0;
    while (!tx_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      check("accept_timeout", 0, 1);
      tx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc      = cyc;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    tx_last  = 1'($urandom);
    resp_sr  = resp;
    start    = acc + (first ? ClkDiv : 0);
    exp_rx   = (miso_sel == 2'd0) ? d : (miso_sel == 2'd1) ? 8'h00 : resp;
    for (int i = 0; i < 8; i++)
      rise_q.push_back({32'(start + ClkDiv + 2 * ClkDiv * i), d[7-i]});
    exp_q.push_back({32'(start + 16 * ClkDiv), exp_rx});
    if (first) begin
      check("csb_min_high", {31'd0, (acc - last_csb_rise) >= ClkDiv}, 1);
      csb_fall_q.push_back(32'(acc));
    end
    if (last) csb_rise_q.push_back(32'(start + 17 * ClkDiv));
    if (toggle) begin
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        tx_valid = 1'($urandom);
        tx_data  = 8'($urandom);
        tx_last  = 1'($urandom);
      end
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_rx();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check("rx_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_q.size() + rise_q.size() + csb_rise_q.size()) != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("done_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    check("ready_low_at_release", {31'd0, tx_ready}, 0);
    @(negedge clk);
    check("ready_after_release", {31'd0, tx_ready}, 1);
  endtask

  int base_rise, base_rx, t;

  initial begin
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_pins", {24'd0, spi_csb, spi_sck, spi_mosi, rx_valid, busy, tx_ready, 2'b00},
          {24'd0, 8'b1000_0000});
    check("reset_rx_data", {24'd0, rx_data}, 0);
    release_reset();

    // single byte, loopback
    miso_sel = 2'd0;
    send_byte(8'hA5, 1'b1, 1'b1, 8'h00, 1'b0);
    wait_done();
    check("csb_low_len", last_low, 36);

    // back-to-back, MISO low
    miso_sel  = 2'd1;
    base_rise = rise_cnt;
    base_rx   = rx_cnt;
    send_byte(8'h3C, 1'b0, 1'b1, 8'h00, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0, 8'h00, 1'b0);
    wait_done();
    check("b2b_sck_pulses", rise_cnt - base_rise, 16);
    check("b2b_rx_pulses", rx_cnt - base_rx, 2);

    // stall in WAIT
    miso_sel = 2'd0;
    send_byte(8'h81, 1'b0, 1'b1, 8'h00, 1'b0);
    wait_rx();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_pins", {29'd0, spi_csb, spi_sck, tx_ready}, 1);
    end
    send_byte(8'h7E, 1'b1, 1'b0, 8'h00, 1'b0);
    wait_done();

    // peripheral response while host sends 0xFF; inputs thrashed during SHIFT
    miso_sel = 2'd2;
    send_byte(8'hFF, 1'b1, 1'b1, 8'h5A, 1'b1);
    wait_done();

    // asynchronous reset after the 4th SCK rise
    miso_sel  = 2'd0;
    base_rise = rise_cnt;
    base_rx   = rx_cnt;
    send_byte(8'h3C, 1'b1, 1'b1, 8'h00, 1'b0);
    t = 0;
    while (rise_cnt - base_rise < 4 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("bit4_timeout", 0, 1);
    #2;
    exp_q.delete();
    rise_q.delete();
    csb_rise_q.delete();
    rst = 1'b1;
    #1;
    check("async_reset_pins", {26'd0, spi_csb, spi_sck, spi_mosi, rx_valid, busy, tx_ready},
          {26'd0, 6'b100000});
    repeat (2) @(negedge clk);
    release_reset();
    repeat (30) @(negedge clk);
    check("reset_no_rx", rx_cnt - base_rx, 0);
    send_byte(8'h11, 1'b1, 1'b1, 8'h00, 1'b0);
    wait_done();

    // random transactions
    for (int tr = 0; tr < 15; tr++) begin
      int n;
      miso_sel = 2'($urandom_range(0, 2));
      n = $urandom_range(1, 3);
      for (int b = 0; b < n; b++) begin
        if (b > 0 && $urandom_range(0, 1) == 1) begin
          wait_rx();
          repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        send_byte(8'($urandom), b == n - 1, b == 0, 8'($urandom), 1'b0);
      end
      wait_done();
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    check("queues_drained",
          exp_q.size() + rise_q.size() + csb_rise_q.size() + csb_fall_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_host_lite.md
SPI_HOST_LITE -- requirements
Module: spi_host_lite

Interface
REQ-001 The block SHALL have parameter ClkDiv, default 2, the number of clk_i cycles per SCK half-period; legal values are 1 to 255.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port tx_valid_i, input, 1 bit: a transmit byte is offered.
REQ-005 The block SHALL have port tx_ready_o, output, 1 bit: the block accepts a byte this cycle.
REQ-006 The block SHALL have port tx_data_i, input, 8 bits: the byte to send, MSB first.
REQ-007 The block SHALL have port tx_last_i, input, 1 bit: this byte ends the transaction (CSB deasserts after it).
REQ-008 The block SHALL have port rx_valid_o, output, 1 bit: a one-cycle pulse marking a received byte; there is no backpressure.
REQ-009 The block SHALL have port rx_data_o, output, 8 bits: the received byte, valid while rx_valid_o=1.
REQ-010 The block SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.
REQ-011 The block SHALL have ports spi_sck_o, spi_csb_o and spi_mosi_o, outputs, 1 bit each, and spi_miso_i, input, 1 bit: SPI mode 0 (CPOL=0, CPHA=0) initiator pins.

Function
REQ-012 A transfer SHALL occur only on a cycle where tx_valid_i and tx_ready_o are both 1; tx_ready_o SHALL be 1 only in IDLE and WAIT.
REQ-013 The state machine SHALL have states IDLE, SETUP, SHIFT, WAIT, HOLD and GAP.
REQ-014 In IDLE, an accepted byte SHALL move the block to SETUP, drive spi_csb_o=0 on the next cycle, and load the shift register; spi_mosi_o SHALL equal tx_data_i[7].
REQ-015 SETUP SHALL last ClkDiv cycles with spi_sck_o=0 and then enter SHIFT.
REQ-016 In SHIFT, each bit SHALL be ClkDiv cycles with SCK low followed by ClkDiv cycles with SCK high; spi_miso_i SHALL be sampled on the cycle SCK rises; MOSI SHALL advance to the next bit when SCK falls.
REQ-017 A byte SHALL take 16*ClkDiv cycles; a 3-bit counter SHALL count bits and a divider counter of width $clog2(ClkDiv+1) SHALL count cycles.
REQ-018 On the edge where the 8th SCK high phase ends, SCK SHALL return to 0, rx_valid_o SHALL pulse for one cycle, and rx_data_o SHALL hold the 8 sampled bits with the first sampled bit in bit 7.
REQ-019 After the byte, if its tx_last was 0 the block SHALL enter WAIT; otherwise it SHALL enter HOLD.
REQ-020 WAIT SHALL keep CSB=0 and SCK=0 indefinitely; an accepted byte SHALL load the shift register and enter SHIFT directly, with no SETUP.
REQ-021 HOLD SHALL last ClkDiv cycles with CSB=0, then the block SHALL enter GAP.
REQ-022 GAP SHALL last ClkDiv cycles with CSB=1, then the block SHALL enter IDLE; the minimum CSB-high time is therefore ClkDiv cycles.
REQ-023 tx_valid_i, tx_data_i and tx_last_i SHALL be ignored whenever tx_ready_o=0.
REQ-024 tx_last_i SHALL be captured at acceptance; later changes to it SHALL have no effect.
REQ-025 In IDLE and GAP, spi_mosi_o SHALL be 0.

Reset
REQ-026 While rst_i=1, the block SHALL asynchronously force: state=IDLE, spi_csb_o=1, spi_sck_o=0, spi_mosi_o=0, rx_valid_o=0, rx_data_o=0, busy_o=0, tx_ready_o=0, and all counters to 0.
REQ-027 A reset asserted mid-transfer SHALL abandon the byte without an rx_valid_o pulse.
REQ-028 tx_ready_o SHALL rise on the first clock edge after rst_i deasserts.
REQ-029 All SPI outputs SHALL be driven directly from flops, with no combinational path from inputs.

Structure
REQ-030 A package spi_host_pkg SHALL hold the state enum (spi_host_state_e) and the constants BitsPerByte=8 and SpiMode=0.
REQ-031 One sub-module, spi_host_tick, SHALL implement the ClkDiv divider and produce rise and fall strobes; the FSM and shift register SHALL stay in spi_host_lite.

Verification (ClkDiv=2, MISO looped to MOSI unless stated)
REQ-032 Single byte: send 0xA5 with last=1. MOSI SHALL be 1,0,1,0,0,1,0,1 at the rising edges; rx_data_o SHALL be 0xA5; CSB SHALL be low for 36 cycles (2+32+2); the next accept SHALL come no earlier than 2 cycles after CSB rises.
REQ-033 Back-to-back: send 0x3C (last=0) then 0xC3 (last=1) with MISO tied to 0. CSB SHALL stay low throughout; there SHALL be 16 SCK pulses; there SHALL be two rx pulses, each 0x00.
REQ-034 Stall: send 0x81 with last=0, then withhold tx_valid for 20 cycles. CSB SHALL stay 0, SCK SHALL stay 0, and tx_ready_o SHALL stay 1 throughout the stall; sending 0x7E (last=1) SHALL then resume SHIFT after 0 SETUP cycles.
REQ-035 Response: a MISO model shifts 0x5A on falling edges while the block transmits 0xFF. rx_data_o SHALL be 0x5A; toggling tx_valid and tx_data during SHIFT SHALL change nothing.
REQ-036 Reset at bit 4: assert rst_i asynchronously. CSB SHALL be 1, SCK 0 and MOSI 0 before the next clock edge; there SHALL be no rx_valid pulse; after release, tx_ready_o SHALL rise 1 cycle later and a new 0x11 transfer SHALL complete normally.
